multi_wait_unit: RTL and testbench
==================================

MULTI_WAIT_UNIT -- requirements
Module: multi_wait_unit

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent wait channels (1..32).
REQ-002 Parameter TMO_W, default 8, width of timeout value and per-channel timeout counter.
REQ-003 Parameter CNT_W, default 16, width of aggregate completion counter.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 arm  input  NUM_CH  per-channel request to begin waiting; sampled each cycle.
REQ-007 cond  input  NUM_CH  per-channel wait condition, level-sensitive, synchronous to clk.
REQ-008 tmo_val  input  TMO_W  timeout in cycles, latched per channel at arm; 0 = no timeout.
REQ-009 cnt_clr  input  1  synchronous clear of done_cnt.
REQ-010 busy  output  NUM_CH  channel is in WAIT.
REQ-011 done  output  NUM_CH  one-cycle pulse: wait satisfied.
REQ-012 timed_out  output  NUM_CH  one-cycle pulse: wait abandoned on timeout.
REQ-013 done_cnt  output  CNT_W  saturating count of done pulses since reset/clear.

Function
REQ-014 Each channel SHALL run FSM states IDLE and WAIT; done/timed_out SHALL be registered outputs.
REQ-015 IDLE with arm=1 and cond=1 in cycle t: done pulse in t+1, state stays IDLE (wait on already-true condition completes immediately).
REQ-016 IDLE with arm=1 and cond=0 in cycle t: state WAIT and busy=1 from t+1; timeout counter loaded with tmo_val.
REQ-017 WAIT with cond=1 sampled in cycle t: done pulse and busy=0 in t+1, state IDLE.
REQ-018 WAIT with cond=0 and nonzero timeout: counter decrements each cycle; cond still 0 in the cycle the counter is 1 -> timed_out pulse, busy=0, IDLE next cycle, i.e. timed_out exactly tmo_val cycles after busy rose.
REQ-019 cond=1 in the same cycle the timeout would fire: done SHALL win; timed_out SHALL NOT assert.
REQ-020 arm while in WAIT SHALL be ignored (no restart, no reload).
REQ-021 arm in the cycle a done/timed_out pulse is output SHALL be accepted (channel already IDLE).
REQ-022 done and timed_out SHALL never assert together on a channel.
REQ-023 done_cnt SHALL add popcount(done) each cycle, saturating at 2^CNT_W-1.
REQ-024 cnt_clr SHALL take priority: done_cnt=0 next cycle, discarding done pulses of that cycle.

Reset
REQ-025 rst_n=0 at a rising edge: all channels IDLE; busy, done, timed_out, done_cnt, timeout counters = 0.
REQ-026 Reset mid-WAIT SHALL abandon the wait silently (no done/timed_out pulse).
REQ-027 arm during reset SHALL be ignored; first accepted arm is the first edge with rst_n=1.

Configuration
REQ-028 Macro WAIT_TIMEOUT_EN SHALL compile in the timeout counters and timed_out logic.
REQ-029 Without WAIT_TIMEOUT_EN: channels wait indefinitely, tmo_val ignored, timed_out tied 0, no counter flops.

Structure
REQ-030 Package wait_pkg SHALL hold the channel state enum typedef (WAIT_IDLE, WAIT_BUSY) and default parameter constants.
REQ-031 Per-channel FSM and timeout counter SHALL be sub-module wait_channel, instantiated NUM_CH times by generate; done_cnt lives in the top.

Verification
REQ-032 Reset released, arm[0]=1 with cond[0]=0, cond[0] raised 5 cycles later -> busy[0] high 5 cycles, done[0] one cycle after cond sampled, done_cnt=1.
REQ-033 arm[1]=1 with cond[1]=1 same cycle -> done[1] next cycle, busy[1] never high.
REQ-034 WAIT_TIMEOUT_EN, tmo_val=3, arm[2], cond[2] held 0 -> timed_out[2] 3 cycles after busy rose, done_cnt unchanged; repeat with cond rising on the expiry cycle -> done only.
REQ-035 All 4 channels complete in the same cycle with done_cnt=2^CNT_W-2 -> done_cnt saturates at 2^CNT_W-1; cnt_clr in that cycle -> 0.
REQ-036 rst_n pulsed low while channel 0 in WAIT -> no pulses, busy[0]=0; re-arm after release completes normally.

Source files
------------

// File: rtl/wait_pkg.sv
// Shared types and default sizing for the multi-channel wait unit.
package wait_pkg;

    typedef enum logic {
        WAIT_IDLE = 1'b0,
        WAIT_BUSY = 1'b1
    } wait_state_t;

    localparam int WAIT_NUM_CH_DEF = 4;
    localparam int WAIT_TMO_W_DEF  = 8;
    localparam int WAIT_CNT_W_DEF  = 16;

endpackage

// File: rtl/wait_channel.sv
// One wait channel: IDLE/WAIT FSM with registered done pulse and, when
// WAIT_TIMEOUT_EN is defined, a down-counting timeout with timed_out pulse.
module wait_channel
    import wait_pkg::*;
#(
    parameter int TMO_W = WAIT_TMO_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_arm,
    input  logic             i_cond,
    input  logic [TMO_W-1:0] i_tmo_val,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timed_out
);

    wait_state_t r_state, w_state_nxt;
    logic        r_done, w_done_nxt;

`ifdef WAIT_TIMEOUT_EN
    logic [TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
    logic             r_timed_out, w_timed_out_nxt;
`else
    logic w_tmo_unused;
    assign w_tmo_unused = ^i_tmo_val;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= WAIT_IDLE;
            r_done      <= 1'b0;
`ifdef WAIT_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_timed_out <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_done      <= w_done_nxt;
`ifdef WAIT_TIMEOUT_EN
            r_tmo_cnt   <= w_tmo_nxt;
            r_timed_out <= w_timed_out_nxt;
`endif
        end
    end

    // cond is tested before the counter so done wins on the expiry cycle
    always_comb begin
        w_state_nxt     = r_state;
        w_done_nxt      = 1'b0;
`ifdef WAIT_TIMEOUT_EN
        w_tmo_nxt       = r_tmo_cnt;
        w_timed_out_nxt = 1'b0;
`endif
        case (r_state)
            WAIT_IDLE: begin
                if (i_arm) begin
                    if (i_cond) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_BUSY;
`ifdef WAIT_TIMEOUT_EN
                        w_tmo_nxt   = i_tmo_val;
`endif
                    end
                end
            end
            WAIT_BUSY: begin
                if (i_cond) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = WAIT_IDLE;
`ifdef WAIT_TIMEOUT_EN
                    w_tmo_nxt   = '0;
                end else if (r_tmo_cnt == TMO_W'(1)) begin
                    w_timed_out_nxt = 1'b1;
                    w_state_nxt     = WAIT_IDLE;
                    w_tmo_nxt       = '0;
                end else if (r_tmo_cnt != '0) begin
                    w_tmo_nxt = r_tmo_cnt - TMO_W'(1);
`endif
                end
            end
            default: w_state_nxt = WAIT_IDLE;
        endcase
    end

    assign o_busy = (r_state == WAIT_BUSY);
    assign o_done = r_done;
`ifdef WAIT_TIMEOUT_EN
    assign o_timed_out = r_timed_out;
`else
    assign o_timed_out = 1'b0;
`endif

endmodule

// File: rtl/multi_wait_unit.sv
// NUM_CH independent wait channels plus a saturating completion counter.
// Timeout support is compiled in only when WAIT_TIMEOUT_EN is defined.
module multi_wait_unit
    import wait_pkg::*;
#(
    parameter int NUM_CH = WAIT_NUM_CH_DEF,
    parameter int TMO_W  = WAIT_TMO_W_DEF,
    parameter int CNT_W  = WAIT_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] arm,
    input  logic [NUM_CH-1:0] cond,
    input  logic [TMO_W-1:0]  tmo_val,
    input  logic              cnt_clr,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] timed_out,
    output logic [CNT_W-1:0]  done_cnt
);

    localparam int POP_W = $clog2(NUM_CH + 1);

    logic [POP_W-1:0] w_done_pop;
    logic [CNT_W:0]   w_cnt_sum;
    logic [CNT_W-1:0] r_done_cnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        wait_channel #(
            .TMO_W(TMO_W)
        ) u_ch (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_arm      (arm[g]),
            .i_cond     (cond[g]),
            .i_tmo_val  (tmo_val),
            .o_busy     (busy[g]),
            .o_done     (done[g]),
            .o_timed_out(timed_out[g])
        );
    end

    // One extra sum bit detects overflow; at most NUM_CH is added per cycle
    assign w_done_pop = POP_W'($countones(done));
    assign w_cnt_sum  = {1'b0, r_done_cnt} + (CNT_W + 1)'(w_done_pop);

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            r_done_cnt <= '0;
        end else if (w_cnt_sum[CNT_W]) begin
            r_done_cnt <= '1;
        end else begin
            r_done_cnt <= w_cnt_sum[CNT_W-1:0];
        end
    end

    assign done_cnt = r_done_cnt;

endmodule

// File: tb/tb_multi_wait_unit.sv
// Directed + random bench for multi_wait_unit using a reference model and
// an expected-result queue; honours WAIT_TIMEOUT_EN when defined.
module tb_multi_wait_unit;

    localparam int NCH  = 4;
    localparam int TW   = 8;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;
`ifdef WAIT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] arm, cond;
    logic [TW-1:0]  tmo_val;
    logic           cnt_clr;
    logic [NCH-1:0] busy, done, timed_out;
    logic [CW-1:0]  done_cnt;

    multi_wait_unit #(
        .NUM_CH(NCH),
        .TMO_W (TW),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arm      (arm),
        .cond     (cond),
        .tmo_val  (tmo_val),
        .cnt_clr  (cnt_clr),
        .busy     (busy),
        .done     (done),
        .timed_out(timed_out),
        .done_cnt (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] busy;
        logic [NCH-1:0] done;
        logic [NCH-1:0] tout;
        logic [CW-1:0]  dcnt;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    logic [NCH-1:0] m_busy = '0;
    logic [NCH-1:0] m_done = '0;
    logic [NCH-1:0] m_tout = '0;
    int             m_tmo[NCH];
    int             m_dcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one rising edge, given the inputs being driven
    task automatic model_edge(input logic [NCH-1:0] a, input logic [NCH-1:0] c,
                              input logic [TW-1:0] tv, input logic clr, input logic rn);
        logic [NCH-1:0] nd, nt, nb;
        int pop;
        pop = $countones(m_done);
        nd = '0; nt = '0; nb = m_busy;
        if (!rn) begin
            nb = '0;
            m_dcnt = 0;
            for (int i = 0; i < NCH; i++) m_tmo[i] = 0;
        end else begin
            if (clr) m_dcnt = 0;
            else m_dcnt = (m_dcnt + pop > CMAX) ? CMAX : m_dcnt + pop;
            for (int i = 0; i < NCH; i++) begin
                if (!m_busy[i]) begin
                    if (a[i] && c[i]) nd[i] = 1'b1;
                    else if (a[i]) begin
                        nb[i] = 1'b1;
                        m_tmo[i] = TMO_EN ? int'(tv) : 0;
                    end
                end else if (c[i]) begin
                    nd[i] = 1'b1;
                    nb[i] = 1'b0;
                end else if (m_tmo[i] == 1) begin
                    nt[i] = 1'b1;
                    nb[i] = 1'b0;
                    m_tmo[i] = 0;
                end else if (m_tmo[i] > 1) begin
                    m_tmo[i]--;
                end
            end
        end
        m_busy = nb;
        m_done = nd;
        m_tout = nt;
    endtask

    task automatic step(input logic [NCH-1:0] a, input logic [NCH-1:0] c,
                        input logic [TW-1:0] tv, input logic clr, input logic rn);
        exp_t e, got;
        @(negedge clk);
        arm = a; cond = c; tmo_val = tv; cnt_clr = clr; rst_n = rn;
        model_edge(a, c, tv, clr, rn);
        e.busy = m_busy; e.done = m_done; e.tout = m_tout; e.dcnt = CW'(m_dcnt);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("busy",      32'(busy),      32'(got.busy));
        chk("done",      32'(done),      32'(got.done));
        chk("timed_out", 32'(timed_out), 32'(got.tout));
        chk("done_cnt",  32'(done_cnt),  32'(got.dcnt));
        chk("exclusive", 32'(done & timed_out), 32'd0);
    endtask

    int hi;

    initial begin
        arm = '0; cond = '0; tmo_val = '0; cnt_clr = 1'b0; rst_n = 1'b0;
        for (int i = 0; i < NCH; i++) m_tmo[i] = 0;

        // Reset with arm asserted: must be ignored
        step(4'hF, 4'h0, 8'd2, 1'b0, 1'b0);
        step(4'hF, 4'h0, 8'd2, 1'b0, 1'b0);

        // Channel 0: wait on cond raised 5 cycles after arm
        hi = 0;
        step(4'h1, 4'h0, 8'd0, 1'b0, 1'b1);
        if (busy[0]) hi++;
        for (int k = 0; k < 4; k++) begin
            step(4'h1, 4'h0, 8'd0, 1'b0, 1'b1);
            if (busy[0]) hi++;
        end
        step(4'h0, 4'h1, 8'd0, 1'b0, 1'b1);
        chk("ch0_busy_cycles", 32'(hi), 32'd5);
        chk("ch0_done_pulse", 32'(done[0]), 32'd1);
        step(4'h0, 4'h0, 8'd0, 1'b0, 1'b1);
        chk("ch0_done_cnt", 32'(done_cnt), 32'd1);

        // Channel 1: condition already true at arm
        step(4'h2, 4'h2, 8'd0, 1'b0, 1'b1);
        chk("ch1_done_now", 32'(done[1]), 32'd1);
        chk("ch1_not_busy", 32'(busy[1]), 32'd0);
        step(4'h0, 4'h0, 8'd0, 1'b0, 1'b1);

        // Channel 2: timeout 3, re-arm with 9 mid-wait must be ignored
        step(4'h4, 4'h0, 8'd3, 1'b0, 1'b1);
        step(4'h4, 4'h0, 8'd9, 1'b0, 1'b1);
        step(4'h0, 4'h0, 8'd0, 1'b0, 1'b1);
        step(4'h0, 4'h0, 8'd0, 1'b0, 1'b1);
        chk("ch2_timeout", 32'(timed_out[2]), 32'(TMO_EN));
        chk("ch2_cnt_unchanged", 32'(done_cnt), 32'd2);
        // Arm in the pulse cycle, then cond rises on the expiry cycle
        step(4'h4, 4'h0, 8'd3, 1'b0, 1'b1);
        step(4'h0, 4'h0, 8'd0, 1'b0, 1'b1);
        step(4'h0, 4'h0, 8'd0, 1'b0, 1'b1);
        step(4'h0, 4'h4, 8'd0, 1'b0, 1'b1);
        chk("ch2_done_wins", 32'(done[2]), 32'd1);
        chk("ch2_no_timeout", 32'(timed_out[2]), 32'd0);
        step(4'h0, 4'h0, 8'd0, 1'b0, 1'b1);

        // Saturation: drive done_cnt to CMAX-1 then four completions together
        step(4'h0, 4'h0, 8'd0, 1'b1, 1'b1);
        chk("clr_zero", 32'(done_cnt), 32'd0);
        for (int k = 0; k < 63; k++) step(4'hF, 4'hF, 8'd0, 1'b0, 1'b1);
        step(4'h3, 4'h3, 8'd0, 1'b0, 1'b1);
        step(4'hF, 4'hF, 8'd0, 1'b0, 1'b1);
        chk("pre_sat", 32'(done_cnt), 32'(CMAX - 1));
        step(4'hF, 4'hF, 8'd0, 1'b0, 1'b1);
        chk("saturated", 32'(done_cnt), 32'(CMAX));
        step(4'h0, 4'h0, 8'd0, 1'b1, 1'b1);
        chk("clr_beats_done", 32'(done_cnt), 32'd0);
        step(4'h0, 4'h0, 8'd0, 1'b0, 1'b1);

        // Reset mid-wait abandons silently; re-arm afterwards completes
        step(4'h1, 4'h0, 8'd5, 1'b0, 1'b1);
        step(4'h0, 4'h0, 8'd0, 1'b0, 1'b1);
        step(4'h1, 4'h1, 8'd0, 1'b0, 1'b0);
        chk("rst_busy0", 32'(busy[0]), 32'd0);
        step(4'h0, 4'h0, 8'd0, 1'b0, 1'b1);
        chk("rst_no_pulse", 32'(done | timed_out), 32'd0);
        step(4'h1, 4'h0, 8'd0, 1'b0, 1'b1);
        step(4'h0, 4'h1, 8'd0, 1'b0, 1'b1);
        chk("rearm_done", 32'(done[0]), 32'd1);

        // Random traffic against the model
        for (int k = 0; k < 200; k++) begin
            step(NCH'($urandom), NCH'($urandom & $urandom), TW'($urandom_range(0, 4)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
